xoodyak_cmd_seq: RTL and testbench

XOODYAK_CMD_SEQ -- requirements
Module: xoodyak_cmd_seq

---
 rtl/xoodyak_pkg.sv | 31 +++
 rtl/xoodyak_seq_mem.sv | 26 ++
 rtl/xoodyak_cmd_seq.sv | 197 +++++++++++++++++++
 tb/tb_xoodyak_cmd_seq.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xoodyak_pkg.sv
// Shared types and constants for the Xoodyak command sequencer.
// Opmode encodings, sequencer states and the program-entry layout.
package xoodyak_pkg;

    localparam int OP_IDLE    = 0;
    localparam int OP_INIT    = 1;
    localparam int OP_NONCE   = 2;
    localparam int OP_ASSOC   = 3;
    localparam int OP_CRYPT   = 4;
    localparam int OP_DECRYPT = 5;
    localparam int OP_SQUEEZE = 6;
    localparam int OP_RATCHET = 7;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_FIN,
        DONE
    } seq_state_t;

    localparam int ENT_OP_W   = 6;
    localparam int ENT_DATA_W = 352;
    localparam int ENT_HOLD_W = 6;

    typedef struct packed {
        logic [ENT_OP_W-1:0]   opmode;
        logic [ENT_DATA_W-1:0] data;
        logic [ENT_HOLD_W-1:0] hold;
    } entry_t;

endpackage

// File: rtl/xoodyak_seq_mem.sv
// Program store: register array, one write port, combinational read.
// Contents are deliberately not reset.
module xoodyak_seq_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 364,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          eph1,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge eph1) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/xoodyak_cmd_seq.sv
// Command sequencer: plays a stored list of opmode/data entries into
// a Xoodyak core, holding each for a count or until finished.
module xoodyak_cmd_seq
    import xoodyak_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 352,
    parameter int OP_W   = 6,
    parameter int HOLD_W = 6,
    parameter int TMO    = 255
) (
    input  logic                     eph1,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [OP_W-1:0]          wr_opmode,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [HOLD_W-1:0]        wr_hold,
    input  logic [$clog2(DEPTH):0]   num_entries,
    input  logic                     loop_en,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     finished,
    output logic [OP_W-1:0]          opmode,
    output logic [DATA_W-1:0]        input_data,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] cur_idx,
    output logic                     tmo_err,
    output logic                     wr_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int NW = IW + 1;
    localparam int TW = $clog2(TMO + 1);
    localparam int EW = OP_W + DATA_W + HOLD_W;

    localparam logic [NW-1:0] DEPTH_N  = NW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
    localparam logic [TW-1:0] TMO_SAT  = TW'(TMO);

    seq_state_t        state, state_n;
    logic [IW-1:0]     idx, idx_n;
    logic [NW-1:0]     n_q, n_n, n_clamp;
    logic              loop_q, loop_n;
    logic [HOLD_W-1:0] hcnt, hcnt_n;
    logic [TW-1:0]     tcnt, tcnt_n;
    logic              tmo_n;
    logic              load, dec, adv, last;
    logic [OP_W-1:0]   op_n;
    logic [DATA_W-1:0] data_n;
    logic [EW-1:0]     rd_entry;
    logic [OP_W-1:0]   rd_op;
    logic [DATA_W-1:0] rd_data;
    logic [HOLD_W-1:0] rd_hold;
    logic              wr_ok;

    assign n_clamp = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
    assign last    = ({1'b0, idx} == n_q - NW'(1));
    assign wr_ok   = wr_en && (state == IDLE);
    assign {rd_op, rd_data, rd_hold} = rd_entry;

    xoodyak_seq_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .eph1  (eph1),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wdata ({wr_opmode, wr_data, wr_hold}),
        .raddr (idx_n),
        .rdata (rd_entry)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        n_n     = n_q;
        loop_n  = loop_q;
        tcnt_n  = tcnt;
        tmo_n   = tmo_err;
        load    = 1'b0;
        dec     = 1'b0;
        adv     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    tmo_n  = 1'b0;
                    n_n    = n_clamp;
                    loop_n = loop_en;
                    idx_n  = '0;
                    if (n_clamp == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n = ISSUE;
                        load    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (hcnt == '0) begin
                    state_n = WAIT_FIN;
                    tcnt_n  = '0;
                end else if (hcnt == HOLD_W'(1)) begin
                    adv = 1'b1;
                end else begin
                    dec = 1'b1;
                end
            end
            WAIT_FIN: begin
                // finished on the expiry cycle still counts as success
                if (finished) begin
                    adv = 1'b1;
                end else if (tcnt >= TMO_LAST) begin
                    tmo_n   = 1'b1;
                    tcnt_n  = TMO_SAT;
                    state_n = IDLE;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            DONE: state_n = IDLE;
        endcase
        if (adv) begin
            if (!last) begin
                idx_n   = idx + IW'(1);
                state_n = ISSUE;
                load    = 1'b1;
            end else if (loop_q) begin
                idx_n   = '0;
                state_n = ISSUE;
                load    = 1'b1;
            end else begin
                state_n = DONE;
            end
        end
        if (abort && state != IDLE) begin
            state_n = IDLE;
            idx_n   = idx;
            tcnt_n  = tcnt;
            tmo_n   = tmo_err;
            load    = 1'b0;
            dec     = 1'b0;
        end
    end

    // Outputs load together with the new index so entries abut.
    always_comb begin
        op_n   = opmode;
        data_n = input_data;
        hcnt_n = hcnt;
        if (load) begin
            op_n   = rd_op;
            data_n = rd_data;
            hcnt_n = rd_hold;
        end else begin
            if (dec) begin
                hcnt_n = hcnt - HOLD_W'(1);
            end
            if (state_n == IDLE || state_n == DONE) begin
                op_n   = '0;
                data_n = '0;
            end
        end
    end

    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            n_q        <= '0;
            loop_q     <= 1'b0;
            hcnt       <= '0;
            tcnt       <= '0;
            tmo_err    <= 1'b0;
            opmode     <= '0;
            input_data <= '0;
            wr_err     <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            n_q        <= n_n;
            loop_q     <= loop_n;
            hcnt       <= hcnt_n;
            tcnt       <= tcnt_n;
            tmo_err    <= tmo_n;
            opmode     <= op_n;
            input_data <= data_n;
            wr_err     <= wr_en && (state != IDLE);
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign cur_idx = idx;

endmodule

// File: tb/tb_xoodyak_cmd_seq.sv
// Scoreboard bench for xoodyak_cmd_seq: directed programs push
// expected output events; a negedge monitor pops and compares.
module tb_xoodyak_cmd_seq;
    import xoodyak_pkg::*;

    localparam int DW = 352;
    localparam int K_BUSY = 0;
    localparam int K_OP   = 1;
    localparam int K_DONE = 2;
    localparam int K_WERR = 3;
    localparam int K_TMO  = 4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [5:0]  op;
        logic [DW-1:0] data;
        logic [3:0]  idx;
        logic        b;
    } ev_t;

    logic          eph1 = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [3:0]    wr_addr = '0;
    logic [5:0]    wr_opmode = '0;
    logic [DW-1:0] wr_data = '0;
    logic [5:0]    wr_hold = '0;
    logic [4:0]    num_entries = '0;
    logic          loop_en = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          finished = 1'b0;
    logic [5:0]    opmode;
    logic [DW-1:0] input_data;
    logic          busy, done, tmo_err, wr_err;
    logic [3:0]    cur_idx;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];

    xoodyak_cmd_seq #(
        .DEPTH(16), .DATA_W(DW), .OP_W(6), .HOLD_W(6), .TMO(8)
    ) dut (
        .eph1(eph1), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_opmode(wr_opmode), .wr_data(wr_data), .wr_hold(wr_hold),
        .num_entries(num_entries), .loop_en(loop_en), .start(start),
        .abort(abort), .finished(finished), .opmode(opmode),
        .input_data(input_data), .busy(busy), .done(done),
        .cur_idx(cur_idx), .tmo_err(tmo_err), .wr_err(wr_err)
    );

    always #5 eph1 = ~eph1;
    always @(posedge eph1) cyc <= cyc + 1;

    function automatic logic [DW-1:0] dpat(int s);
        logic [31:0] w;
        w = 32'hA5C3_0000 ^ 32'(s * 32'h0001_0101);
        return {11{w}};
    endfunction

    task automatic push(int c, int k, int op, logic [DW-1:0] d, int ix, logic b);
        ev_t e;
        e.cyc = c; e.kind = k; e.op = 6'(op);
        e.data = d; e.idx = 4'(ix); e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic exp_b(int c, int k, logic b);
        push(c, k, 0, '0, 0, b);
    endtask

    task automatic exp_op(int c, int op, logic [DW-1:0] d, int ix);
        push(c, K_OP, op, d, ix, 1'b0);
    endtask

    task automatic see(int k, logic b);
        ev_t a, e;
        bit ok;
        a.cyc = cyc; a.kind = k; a.op = opmode;
        a.data = input_data; a.idx = cur_idx; a.b = b;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d op=%0d idx=%0d b=%0d",
                     k, a.cyc, a.op, a.idx, b);
            return;
        end
        e = exp_q.pop_front();
        ok = (a.cyc == e.cyc) && (a.kind == e.kind);
        if (ok && k == K_OP)
            ok = (a.op == e.op) && (a.data == e.data) && (a.idx == e.idx);
        if (ok && (k == K_BUSY || k == K_TMO))
            ok = (a.b == e.b);
        if (!ok) begin
            failures++;
            $display("FAIL event got kind=%0d cyc=%0d op=%0d idx=%0d b=%0d d=%h expected kind=%0d cyc=%0d op=%0d idx=%0d b=%0d d=%h",
                     a.kind, a.cyc, a.op, a.idx, a.b, a.data[31:0],
                     e.kind, e.cyc, e.op, e.idx, e.b, e.data[31:0]);
        end
    endtask

    logic [5:0]    p_op = '0;
    logic [DW-1:0] p_data = '0;
    logic [3:0]    p_idx = '0;
    logic          p_busy = 1'b0;
    logic          p_tmo = 1'b0;

    always @(negedge eph1) begin
        if (!reset) begin
            checks++;
            if (opmode !== '0 || input_data !== '0 || busy !== 1'b0 ||
                done !== 1'b0 || cur_idx !== '0 || tmo_err !== 1'b0 ||
                wr_err !== 1'b0) begin
                failures++;
                $display("FAIL reset_state op=%0d busy=%0b done=%0b idx=%0d tmo=%0b werr=%0b expected all zero",
                         opmode, busy, done, cur_idx, tmo_err, wr_err);
            end
        end
        if (busy !== p_busy) see(K_BUSY, busy);
        if (opmode !== p_op || input_data !== p_data || cur_idx !== p_idx)
            see(K_OP, 1'b0);
        if (done === 1'b1) see(K_DONE, 1'b1);
        if (wr_err === 1'b1) see(K_WERR, 1'b1);
        if (tmo_err !== p_tmo) see(K_TMO, tmo_err);
        p_busy = busy; p_op = opmode; p_data = input_data;
        p_idx = cur_idx; p_tmo = tmo_err;
    end

    task automatic tick();
        @(posedge eph1);
        #1;
    endtask

    task automatic wait_to(int c);
        while (cyc < c) tick();
    endtask

    task automatic wr(int a, int op, int h, logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_opmode = 6'(op);
        wr_hold = 6'(h); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic go(int n, logic lp, output int s);
        num_entries = 5'(n); loop_en = lp; start = 1'b1;
        tick();
        start = 1'b0;
        s = cyc;
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() > 0 && b < 300) begin
            tick();
            b++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        #1 reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // three-entry program, last entry waits for finished
        wr(0, OP_INIT, 6, dpat(1));
        wr(1, OP_NONCE, 3, dpat(2));
        wr(2, OP_ASSOC, 0, dpat(3));
        go(3, 1'b0, s);
        exp_b(s, K_BUSY, 1'b1);
        exp_op(s, OP_INIT, dpat(1), 0);
        exp_op(s + 6, OP_NONCE, dpat(2), 1);
        exp_op(s + 9, OP_ASSOC, dpat(3), 2);
        exp_op(s + 15, 0, '0, 2);
        exp_b(s + 15, K_DONE, 1'b1);
        exp_b(s + 16, K_BUSY, 1'b0);
        wait_to(s + 14);
        finished = 1'b1; tick(); finished = 1'b0;
        drain();

        // looping program, start while busy ignored, then abort
        wr(0, OP_INIT, 2, dpat(11));
        wr(1, OP_NONCE, 2, dpat(12));
        go(2, 1'b1, s);
        exp_b(s, K_BUSY, 1'b1);
        exp_op(s, OP_INIT, dpat(11), 0);
        exp_op(s + 2, OP_NONCE, dpat(12), 1);
        exp_op(s + 4, OP_INIT, dpat(11), 0);
        exp_op(s + 6, OP_NONCE, dpat(12), 1);
        exp_op(s + 8, OP_INIT, dpat(11), 0);
        exp_b(s + 9, K_BUSY, 1'b0);
        exp_op(s + 9, 0, '0, 0);
        wait_to(s + 2);
        start = 1'b1; tick(); start = 1'b0;
        wait_to(s + 8);
        abort = 1'b1; tick(); abort = 1'b0;
        drain();

        // finished never arrives: timeout after 8 wait cycles
        wr(0, OP_CRYPT, 0, dpat(7));
        go(1, 1'b0, s);
        exp_b(s, K_BUSY, 1'b1);
        exp_op(s, OP_CRYPT, dpat(7), 0);
        exp_b(s + 9, K_BUSY, 1'b0);
        exp_op(s + 9, 0, '0, 0);
        exp_b(s + 9, K_TMO, 1'b1);
        drain();

        // restart clears tmo_err; finished on the expiry cycle wins
        go(1, 1'b0, s);
        exp_b(s, K_BUSY, 1'b1);
        exp_op(s, OP_CRYPT, dpat(7), 0);
        exp_b(s, K_TMO, 1'b0);
        exp_op(s + 9, 0, '0, 0);
        exp_b(s + 9, K_DONE, 1'b1);
        exp_b(s + 10, K_BUSY, 1'b0);
        wait_to(s + 8);
        finished = 1'b1; tick(); finished = 1'b0;
        drain();

        // empty program
        go(0, 1'b0, s);
        exp_b(s, K_BUSY, 1'b1);
        exp_b(s, K_DONE, 1'b1);
        exp_b(s + 1, K_BUSY, 1'b0);
        drain();

        // write while busy rejected, start while busy ignored
        wr(0, OP_INIT, 3, dpat(4));
        wr(1, OP_NONCE, 3, dpat(5));
        go(2, 1'b0, s);
        exp_b(s, K_BUSY, 1'b1);
        exp_op(s, OP_INIT, dpat(4), 0);
        exp_b(s + 2, K_WERR, 1'b1);
        exp_op(s + 3, OP_NONCE, dpat(5), 1);
        exp_op(s + 6, 0, '0, 1);
        exp_b(s + 6, K_DONE, 1'b1);
        exp_b(s + 7, K_BUSY, 1'b0);
        wait_to(s + 1);
        wr(1, OP_RATCHET, 1, dpat(66));
        wait_to(s + 3);
        start = 1'b1; tick(); start = 1'b0;
        drain();

        // write and start in one cycle: run sees old entry 0
        wr_en = 1'b1; wr_addr = 4'd0; wr_opmode = 6'(OP_DECRYPT);
        wr_hold = 6'd1; wr_data = dpat(9);
        num_entries = 5'd1; loop_en = 1'b0; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0; s = cyc;
        exp_b(s, K_BUSY, 1'b1);
        exp_op(s, OP_INIT, dpat(4), 0);
        exp_op(s + 3, 0, '0, 0);
        exp_b(s + 3, K_DONE, 1'b1);
        exp_b(s + 4, K_BUSY, 1'b0);
        drain();
        go(1, 1'b0, s);
        exp_b(s, K_BUSY, 1'b1);
        exp_op(s, OP_DECRYPT, dpat(9), 0);
        exp_op(s + 1, 0, '0, 0);
        exp_b(s + 1, K_DONE, 1'b1);
        exp_b(s + 2, K_BUSY, 1'b0);
        drain();

        // num_entries above DEPTH clamps to 16
        for (int i = 0; i < 16; i++) wr(i, (i % 7) + 1, 1, dpat(100 + i));
        go(31, 1'b0, s);
        exp_b(s, K_BUSY, 1'b1);
        for (int i = 0; i < 16; i++)
            exp_op(s + i, (i % 7) + 1, dpat(100 + i), i);
        exp_op(s + 16, 0, '0, 15);
        exp_b(s + 16, K_DONE, 1'b1);
        exp_b(s + 17, K_BUSY, 1'b0);
        drain();

        // asynchronous reset during the second entry, then replay
        wr(0, OP_INIT, 3, dpat(4));
        wr(1, OP_NONCE, 3, dpat(5));
        go(2, 1'b0, s);
        exp_b(s, K_BUSY, 1'b1);
        exp_op(s, OP_INIT, dpat(4), 0);
        exp_op(s + 3, OP_NONCE, dpat(5), 1);
        exp_b(s + 4, K_BUSY, 1'b0);
        exp_op(s + 4, 0, '0, 0);
        wait_to(s + 4);
        #1 reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        drain();
        go(2, 1'b0, s);
        exp_b(s, K_BUSY, 1'b1);
        exp_op(s, OP_INIT, dpat(4), 0);
        exp_op(s + 3, OP_NONCE, dpat(5), 1);
        exp_op(s + 6, 0, '0, 1);
        exp_b(s + 6, K_DONE, 1'b1);
        exp_b(s + 7, K_BUSY, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
